ram_port_arbiter: RTL and testbench

- Sits directly downstream of the data memory shim and its instruction-side twin; consumes their byte-wide RAM request bundles and drives the single byte-wide RAM port.
- Grants one shim at a time.
- Holds the grant for the whole multi-byte transaction while that shim keeps its use line high.
- Returns the RAM read byte to the owner.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the byte-wide RAM port arbiter and the two memory shims.
package ram_arb_pkg;

  // Default widths shared with the instruction and data shims
  localparam int RAM_ADDR_W = 32;
  localparam int RAM_DATA_W = 8;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_e;

  // Owner tag used for read-return routing and round-robin history
  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: grants the single byte-wide RAM port to either the
// instruction shim or the data shim, holds the grant while the owner keeps its
// use line high, and routes the RAM read byte back to whichever shim issued it.
//
// Build option: define ARB_ROUND_ROBIN_EN to break simultaneous requests from
// IDLE in favour of the shim that did not own the RAM last. Without it the data
// shim wins every tie.
//
// Handshake: x_use is a level request; x_grant rises the cycle after the FSM
// takes ownership and stays high while x_use stays high. A shim only drives
// strobes while it sees x_grant; strobes from the non-owner are masked here.
// data_from_RAM is valid the cycle after RAMread and appears on the issuing
// shim's x_rdata in that same cycle, then is held until the next return.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_use,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  input  logic              d_use,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_write,
  input  logic              d_read,
  output logic              i_grant,
  output logic              d_grant,
  output logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] RAMaddr,
  output logic [DATA_W-1:0] data_to_RAM,
  output logic              RAMwrite,
  output logic              RAMread,
  input  logic [DATA_W-1:0] data_from_RAM,
  output logic [1:0]        dbg_state
);

  arb_state_e        state_q, state_d;
  logic              i_grant_q, i_grant_d;
  logic              d_grant_q, d_grant_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_tag_q, rd_tag_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              tie_to_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // Round-robin tie break: the shim that did not own the RAM last goes first
  always_comb begin
    tie_to_i = (last_owner_q == TAG_D);
  end

  // Remember the owner each time the FSM enters an ownership state
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_d == OWN_I && state_q != OWN_I) last_owner_d = TAG_I;
    if (state_d == OWN_D && state_q != OWN_D) last_owner_d = TAG_D;
  end

  // Ownership history register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_owner_q <= TAG_I;
    else       last_owner_q <= last_owner_d;
  end
`else
  // Fixed priority: the data shim wins every tie
  always_comb begin
    tie_to_i = 1'b0;
  end
`endif

  // Next-state logic: hold while the owner keeps use high, hand off directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_use && d_use) state_d = tie_to_i ? OWN_I : OWN_D;
        else if (d_use)     state_d = OWN_D;
        else if (i_use)     state_d = OWN_I;
      end
      OWN_I: begin
        if (!i_use) state_d = d_use ? OWN_D : IDLE;
      end
      OWN_D: begin
        if (!d_use) state_d = i_use ? OWN_I : IDLE;
      end
      default: state_d = IDLE;
    endcase
    i_grant_d = (state_d == OWN_I);
    d_grant_d = (state_d == OWN_D);
  end

  // FSM state and registered grant decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      i_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_grant_q <= i_grant_d;
      d_grant_q <= d_grant_d;
    end
  end

  // RAM-side mux: only the owner's strobes and address reach the RAM
  always_comb begin
    RAMaddr     = '0;
    data_to_RAM = '0;
    RAMwrite    = 1'b0;
    RAMread     = 1'b0;
    case (state_q)
      OWN_I: begin
        RAMaddr = i_addr;
        RAMread = i_read;
      end
      OWN_D: begin
        RAMaddr     = d_addr;
        data_to_RAM = d_wdata;
        RAMwrite    = d_write;
        RAMread     = d_read;
      end
      default: ;
    endcase
  end

  // Read-return router: tag each read with its issuer, steer the returning byte
  always_comb begin
    rd_pend_d = RAMread;
    rd_tag_d  = rd_tag_q;
    if (RAMread) rd_tag_d = (state_q == OWN_D) ? TAG_D : TAG_I;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (rd_pend_q && rd_tag_q == TAG_I) i_rdata_d = data_from_RAM;
    if (rd_pend_q && rd_tag_q == TAG_D) d_rdata_d = data_from_RAM;
    i_rdata = i_rdata_d;
    d_rdata = d_rdata_d;
  end

  // Read tag and held return bytes; reset discards any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_tag_q  <= TAG_I;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Grant and debug outputs
  always_comb begin
    i_grant   = i_grant_q;
    d_grant   = d_grant_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed scenarios with a byte scoreboard for
// RAM writes and read returns.
module tb_ram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          i_use, i_read, d_use, d_write, d_read;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_grant, d_grant, RAMwrite, RAMread;
  logic [DW-1:0] i_rdata, d_rdata, data_to_RAM, data_from_RAM;
  logic [AW-1:0] RAMaddr;
  logic [1:0]    dbg_state;

  logic [DW-1:0]    ret_byte;
  logic [DW-1:0]    exp_q[$];
  logic [AW+DW-1:0] wr_q[$];

  int vectors;
  int miscompares;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .i_use(i_use), .i_addr(i_addr), .i_read(i_read),
    .d_use(d_use), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_write(d_write), .d_read(d_read),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_rdata(i_rdata), .d_rdata(d_rdata),
    .RAMaddr(RAMaddr), .data_to_RAM(data_to_RAM),
    .RAMwrite(RAMwrite), .RAMread(RAMread),
    .data_from_RAM(data_from_RAM), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // RAM model: the byte chosen by the test is returned the cycle after RAMread
  always @(posedge clk) begin
    data_from_RAM <= RAMread ? ret_byte : 8'h00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_use = 0; i_read = 0; i_addr = '0;
    d_use = 0; d_write = 0; d_read = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    d_use = 1; d_addr = 32'h55; d_read = 1; d_write = 1; d_wdata = 8'h12;
    ret_byte = 8'h00;
    tick(); tick();
    vectors++;
    if ({i_grant, d_grant, RAMwrite, RAMread} !== 4'b0 || RAMaddr !== '0 ||
        data_to_RAM !== '0 || i_rdata !== '0 || d_rdata !== '0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got gi=%b gd=%b w=%b r=%b addr=%h wd=%h ird=%h drd=%h st=%0d, required all 0",
               i_grant, d_grant, RAMwrite, RAMread, RAMaddr, data_to_RAM, i_rdata, d_rdata, dbg_state);
    end
    d_read = 0; d_write = 0;
    reset = 0;
    tick();
    vectors++;
    if (d_grant !== 1'b1 || i_grant !== 1'b0 || RAMaddr !== 32'h55) begin
      miscompares++;
      $display("FAIL reset_release_grant: got gd=%b gi=%b addr=%h, required gd=1 gi=0 addr=00000055",
               d_grant, i_grant, RAMaddr);
    end
    d_use = 0;
    tick();
    vectors++;
    if (d_grant !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL release_to_idle: got gd=%b st=%0d, required gd=0 st=0", d_grant, dbg_state);
    end
  endtask

  task automatic test_write_burst();
    logic [DW-1:0] bytes [4];
    logic [AW+DW-1:0] exp;
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
    d_use = 1; d_addr = 32'h100;
    tick();
    i_use = 1;
    for (int k = 0; k < 4; k++) begin
      i_addr  = AW'($urandom_range(0, 255));
      i_read  = 1'($urandom_range(0, 1));
      d_addr  = 32'h100 + AW'(k);
      d_wdata = bytes[k];
      d_write = 1;
      wr_q.push_back({d_addr, d_wdata});
      #1;
      exp = wr_q.pop_front();
      vectors++;
      if (RAMwrite !== 1'b1 || {RAMaddr, data_to_RAM} !== exp || RAMread !== 1'b0 ||
          i_grant !== 1'b0 || d_grant !== 1'b1) begin
        miscompares++;
        $display("FAIL write_burst[%0d]: got w=%b r=%b addr=%h data=%h gi=%b gd=%b, required w=1 r=0 addr=%h data=%h gi=0 gd=1",
                 k, RAMwrite, RAMread, RAMaddr, data_to_RAM, i_grant, d_grant, exp[AW+DW-1:DW], exp[DW-1:0]);
      end
      tick();
    end
    d_write = 0; i_read = 0; d_use = 0;
    tick();
    vectors++;
    if (i_grant !== 1'b1 || d_grant !== 1'b0 || dbg_state !== 2'd1) begin
      miscompares++;
      $display("FAIL burst_handoff: got gi=%b gd=%b st=%0d, required gi=1 gd=0 st=1", i_grant, d_grant, dbg_state);
    end
    i_use = 0;
    tick();
    vectors++;
    if (i_grant !== 1'b0 || RAMaddr !== '0 || RAMwrite !== 1'b0 || RAMread !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_outputs: got gi=%b addr=%h w=%b r=%b, required 0", i_grant, RAMaddr, RAMwrite, RAMread);
    end
  endtask

  task automatic test_tie();
    logic exp_i;
    // Prior short D transaction so the round-robin history points at D
    d_use = 1;
    tick();
    d_use = 0;
    tick();
    i_use = 1; d_use = 1;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    exp_i = 1'b1;
`else
    exp_i = 1'b0;
`endif
    vectors++;
    if (i_grant !== exp_i || d_grant !== !exp_i) begin
      miscompares++;
      $display("FAIL tie_break: got gi=%b gd=%b, required gi=%b gd=%b", i_grant, d_grant, exp_i, !exp_i);
    end
    i_use = 0; d_use = 0;
    tick();
  endtask

  task automatic test_handoff_read();
    logic [DW-1:0] d_prev, exp;
    d_use = 1;
    tick();
    d_use = 0; i_use = 1; i_addr = 32'h40;
    tick();
    vectors++;
    if (i_grant !== 1'b1 || d_grant !== 1'b0 || dbg_state !== 2'd1) begin
      miscompares++;
      $display("FAIL handoff_no_bubble: got gi=%b gd=%b st=%0d, required gi=1 gd=0 st=1", i_grant, d_grant, dbg_state);
    end
    d_prev = d_rdata;
    i_read = 1; ret_byte = 8'h5A;
    exp_q.push_back(8'h5A);
    #1;
    vectors++;
    if (RAMread !== 1'b1 || RAMaddr !== 32'h40) begin
      miscompares++;
      $display("FAIL i_read_issue: got r=%b addr=%h, required r=1 addr=00000040", RAMread, RAMaddr);
    end
    tick();
    i_read = 0;
    exp = exp_q.pop_front();
    vectors++;
    if (i_rdata !== exp || d_rdata !== d_prev) begin
      miscompares++;
      $display("FAIL i_read_return: got ird=%h drd=%h, required ird=%h drd=%h", i_rdata, d_rdata, exp, d_prev);
    end
    tick();
    vectors++;
    if (i_rdata !== exp) begin
      miscompares++;
      $display("FAIL i_rdata_hold: got %h, required %h", i_rdata, exp);
    end
    i_use = 0;
    tick();
  endtask

  task automatic test_read_in_flight();
    logic [DW-1:0] i_prev, exp;
    d_use = 1;
    tick();
    d_read = 1; d_addr = 32'h20; ret_byte = 8'h11;
    exp_q.push_back(8'h11);
    tick();
    exp = exp_q.pop_front();
    vectors++;
    if (d_rdata !== exp) begin
      miscompares++;
      $display("FAIL d_read_return: got %h, required %h", d_rdata, exp);
    end
    i_prev = i_rdata;
    d_addr = 32'h21; d_use = 0; i_use = 1; ret_byte = 8'h3C;
    exp_q.push_back(8'h3C);
    #1;
    vectors++;
    if (RAMread !== 1'b1 || RAMaddr !== 32'h21) begin
      miscompares++;
      $display("FAIL last_d_read_issue: got r=%b addr=%h, required r=1 addr=00000021", RAMread, RAMaddr);
    end
    tick();
    d_read = 0;
    exp = exp_q.pop_front();
    vectors++;
    if (d_rdata !== exp || i_rdata !== i_prev || i_grant !== 1'b1) begin
      miscompares++;
      $display("FAIL inflight_return: got drd=%h ird=%h gi=%b, required drd=%h ird=%h gi=1",
               d_rdata, i_rdata, i_grant, exp, i_prev);
    end
    i_use = 0;
    tick();
  endtask

  task automatic test_non_owner();
    logic [DW-1:0] i_prev, exp;
    d_use = 1;
    tick();
    i_use = 0; i_read = 1; i_addr = 32'h77; d_addr = 32'h30; d_read = 0;
    #1;
    vectors++;
    if (RAMread !== 1'b0 || RAMaddr !== 32'h30) begin
      miscompares++;
      $display("FAIL non_owner_masked: got r=%b addr=%h, required r=0 addr=00000030", RAMread, RAMaddr);
    end
    i_prev = i_rdata;
    d_read = 1; ret_byte = 8'h99;
    exp_q.push_back(8'h99);
    #1;
    vectors++;
    if (RAMread !== 1'b1 || RAMaddr !== 32'h30) begin
      miscompares++;
      $display("FAIL owner_read: got r=%b addr=%h, required r=1 addr=00000030", RAMread, RAMaddr);
    end
    tick();
    exp = exp_q.pop_front();
    vectors++;
    if (d_rdata !== exp || i_rdata !== i_prev) begin
      miscompares++;
      $display("FAIL non_owner_return: got drd=%h ird=%h, required drd=%h ird=%h", d_rdata, i_rdata, exp, i_prev);
    end
    d_read = 0; i_read = 0;
    tick();
  endtask

  task automatic test_random_reads();
    logic [DW-1:0] exp;
    for (int k = 0; k < 8; k++) begin
      d_addr   = AW'($urandom_range(0, 1023));
      d_read   = 1;
      ret_byte = 8'($urandom_range(0, 255));
      exp_q.push_back(ret_byte);
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if (d_rdata !== exp) begin
        miscompares++;
        $display("FAIL random_read[%0d]: got %h, required %h", k, d_rdata, exp);
      end
    end
    d_read = 0; d_use = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_use = 1;
    tick();
    d_read = 1; ret_byte = 8'h44;
    tick();
    reset = 1;
    #1;
    vectors++;
    if (d_grant !== 1'b0 || RAMread !== 1'b0 || d_rdata !== '0 || i_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got gd=%b r=%b drd=%h ird=%h, required all 0", d_grant, RAMread, d_rdata, i_rdata);
    end
    idle_inputs();
    tick();
    reset = 0;
    tick();
    vectors++;
    if (d_rdata !== '0 || i_rdata !== '0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid_after: got drd=%h ird=%h st=%0d, required 0", d_rdata, i_rdata, dbg_state);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_burst();
    test_tie();
    test_handoff_read();
    test_read_in_flight();
    test_non_owner();
    test_random_reads();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
